reduce_gate_seq: RTL and testbench

- Multi-cycle, parametrised wide reduction gate; successor to the fixed-fan-in or/nor cells used in gate-level test circuits.
- Reduces an N-bit operand with a K-input gate, one chunk per cycle, under OR, NOR, AND or NAND mode selected per transaction.
- Optional early termination once the result is decided.
- Sits between stimulus/registers and downstream logic; uses a valid/ready handshake on both sides.

---
 rtl/reduce_pkg.sv | 35 +++
 rtl/reduce_gate_seq_chunk.sv | 20 ++
 rtl/reduce_gate_seq.sv | 109 ++++++++++
 tb/tb_reduce_gate_seq.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/reduce_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | reduce_pkg : shared types and helpers for the sequential reducer   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package reduce_pkg;

  typedef enum logic [1:0] {
    MODE_OR   = 2'b00,
    MODE_NOR  = 2'b01,
    MODE_AND  = 2'b10,
    MODE_NAND = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    REDUCE = 2'b01,
    DONE   = 2'b10
  } state_e;

  // AND-family modes start from 1 and are decided by a 0; OR-family the reverse.
  function automatic logic identity(input mode_e m);
    return m[1];
  endfunction

  function automatic logic dominant(input mode_e m);
    return ~m[1];
  endfunction

  function automatic logic inverts(input mode_e m);
    return m[0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/reduce_gate_seq_chunk.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | reduce_chunk : combinational K-bit OR/AND reduction of one chunk   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module reduce_chunk
  import reduce_pkg::*;
#(
  parameter int K = 3
) (
  input  logic [K-1:0] chunk_i,
  input  mode_e        mode_i,
  output logic         red_o
);

  // Output inversion for NOR/NAND is applied once at the result, not per chunk.
  assign red_o = identity(mode_i) ? (&chunk_i) : (|chunk_i);

endmodule
`default_nettype wire

// File: rtl/reduce_gate_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | reduce_gate_seq : multi-cycle N-bit OR/NOR/AND/NAND reduction gate |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module reduce_gate_seq
  import reduce_pkg::*;
#(
  parameter int N          = 7,
  parameter int K          = 3,
  parameter bit EARLY_EXIT = 1'b0,
  localparam int C         = (N + K - 1) / K,
  localparam int CW        = $clog2(C + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [N-1:0]  data_i,
  input  logic [1:0]    mode_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  output logic          y_o,
  output logic [CW-1:0] count_o,
  output logic          out_valid_o,
  input  logic          out_ready_i
);

  localparam int            PW     = C * K;
  localparam logic [CW-1:0] C_LAST = CW'(C);

  state_e          state_q, state_d;
  mode_e           mode_q, mode_d;
  logic [PW-1:0]   shreg_q, shreg_d;
  logic            acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            chunk_red;
  logic            acc_new;
  logic [CW-1:0]   cnt_inc;
  mode_e           mode_in;

  assign mode_in = mode_e'(mode_i);

  reduce_chunk #(.K(K)) u_chunk (
    .chunk_i (shreg_q[K-1:0]),
    .mode_i  (mode_q),
    .red_o   (chunk_red)
  );

  // The accumulator only ever moves from identity to dominant, never back.
  assign acc_new = (chunk_red == dominant(mode_q)) ? chunk_red : acc_q;
  assign cnt_inc = cnt_q + CW'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      mode_q  <= MODE_OR;
      shreg_q <= '0;
      acc_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      shreg_q <= shreg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    shreg_d = shreg_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          // Bits above N are pre-filled with identity so the last chunk pads itself.
          mode_d            = mode_in;
          shreg_d           = {PW{identity(mode_in)}};
          shreg_d[N-1:0]    = data_i;
          acc_d             = identity(mode_in);
          cnt_d             = '0;
          state_d           = REDUCE;
        end
      end
      REDUCE: begin
        shreg_d = shreg_q >> K;
        acc_d   = acc_new;
        cnt_d   = cnt_inc;
        if ((cnt_inc == C_LAST) || (EARLY_EXIT && (acc_new == dominant(mode_q)))) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign y_o         = out_valid_o ? (acc_q ^ inverts(mode_q)) : 1'b0;
  assign count_o     = out_valid_o ? cnt_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_reduce_gate_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_reduce_gate_seq : scoreboard bench over three configurations    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_reduce_gate_seq;

  typedef struct {
    logic       y;
    logic [1:0] cnt;
    int         acc_cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data = '0;
  logic [1:0] mode = '0;
  logic [2:0] in_valid = '0;
  logic       out_ready = 1'b1;
  logic       rand_ready = 1'b0;

  logic [2:0] in_ready, out_valid, y;
  logic [1:0] cnt0, cnt1;
  logic [0:0] cnt2;
  logic [1:0] cnt_w [3];

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb [3][$];
  exp_t cur [3];
  logic prev_ov [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  reduce_gate_seq #(.N(7), .K(3), .EARLY_EXIT(1'b0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .data_i(data[6:0]), .mode_i(mode), .in_valid_i(in_valid[0]),
    .in_ready_o(in_ready[0]), .y_o(y[0]), .count_o(cnt0), .out_valid_o(out_valid[0]),
    .out_ready_i(out_ready));
  reduce_gate_seq #(.N(7), .K(3), .EARLY_EXIT(1'b1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .data_i(data[6:0]), .mode_i(mode), .in_valid_i(in_valid[1]),
    .in_ready_o(in_ready[1]), .y_o(y[1]), .count_o(cnt1), .out_valid_o(out_valid[1]),
    .out_ready_i(out_ready));
  reduce_gate_seq #(.N(8), .K(8), .EARLY_EXIT(1'b0)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .data_i(data), .mode_i(mode), .in_valid_i(in_valid[2]),
    .in_ready_o(in_ready[2]), .y_o(y[2]), .count_o(cnt2), .out_valid_o(out_valid[2]),
    .out_ready_i(out_ready));

  assign cnt_w[0] = cnt0;
  assign cnt_w[1] = cnt1;
  assign cnt_w[2] = {1'b0, cnt2};

  function automatic int cfg_n(input int i);
    return (i == 2) ? 8 : 7;
  endfunction
  function automatic int cfg_k(input int i);
    return (i == 2) ? 8 : 3;
  endfunction

  // Reference: result is decided by the lowest bit carrying the dominant value.
  function automatic exp_t ref_model(input int i, input logic [7:0] d, input logic [1:0] m);
    exp_t e;
    int   n = cfg_n(i);
    int   k = cfg_k(i);
    int   c = (n + k - 1) / k;
    int   pos = -1;
    logic dom_bit = ~m[1];
    for (int b = n - 1; b >= 0; b--) if (d[b] == dom_bit) pos = b;
    e.y       = ((pos >= 0) ? dom_bit : ~dom_bit) ^ m[0];
    e.cnt     = (i == 1 && pos >= 0) ? 2'(pos / k + 1) : 2'(c);
    e.acc_cyc = 0;
    return e;
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic send(input int i, input logic [7:0] d, input logic [1:0] m, input bit expect_res);
    exp_t e;
    int   t;
    @(negedge clk);
    data = d;
    mode = m;
    in_valid[i] = 1'b1;
    for (t = 0; t < 200 && !in_ready[i]; t++) @(negedge clk);
    if (!in_ready[i]) begin
      check("accept_timeout", 0, 1);
    end else if (expect_res) begin
      e = ref_model(i, d, m);
      e.acc_cyc = cyc + 1;
      sb[i].push_back(e);
    end
    @(negedge clk);
    in_valid[i] = 1'b0;
    data = 8'($urandom);
    mode = 2'($urandom);
  endtask

  always @(negedge clk) begin
    if (rand_ready) out_ready <= ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        prev_ov[i] = 1'b0;
      end else begin
        if (out_valid[i] && !prev_ov[i]) begin
          if (sb[i].size() == 0) begin
            check("unexpected_result", 1, 0);
          end else begin
            cur[i] = sb[i].pop_front();
            check("y", int'(y[i]), int'(cur[i].y));
            check("count", int'(cnt_w[i]), int'(cur[i].cnt));
            check("latency", cyc - cur[i].acc_cyc, int'(cur[i].cnt));
          end
        end else if (out_valid[i]) begin
          check("y_held", int'(y[i]), int'(cur[i].y));
          check("count_held", int'(cnt_w[i]), int'(cur[i].cnt));
        end
        if (out_valid[i]) check("in_ready_in_done", int'(in_ready[i]), 0);
        prev_ov[i] = out_valid[i];
      end
    end
  end

  initial begin
    int t;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rst_in_ready", int'(in_ready[i]), 1);
      check("rst_out_valid", int'(out_valid[i]), 0);
      check("rst_y", int'(y[i]), 0);
      check("rst_count", int'(cnt_w[i]), 0);
    end

    send(0, 8'h40, 2'b00, 1'b1);
    send(0, 8'h00, 2'b00, 1'b1);
    send(0, 8'h00, 2'b01, 1'b1);
    send(0, 8'h7F, 2'b10, 1'b1);
    send(0, 8'h7F, 2'b11, 1'b1);
    send(1, 8'h01, 2'b00, 1'b1);
    send(1, 8'h7E, 2'b10, 1'b1);
    send(2, 8'hFF, 2'b11, 1'b1);
    repeat (6) @(negedge clk);

    // Backpressure: result held for five cycles while another operand waits.
    out_ready = 1'b0;
    fork
      begin
        for (int w = 0; w < 50 && !out_valid[0]; w++) @(negedge clk);
        repeat (5) @(negedge clk);
        out_ready = 1'b1;
      end
    join_none
    send(0, 8'h40, 2'b01, 1'b1);
    send(0, 8'h7F, 2'b10, 1'b1);
    repeat (6) @(negedge clk);

    // Reset mid-reduction aborts the transaction with no result.
    send(0, 8'h7F, 2'b10, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("abort_in_ready", int'(in_ready[0]), 1);
    check("abort_out_valid", int'(out_valid[0]), 0);
    check("abort_y", int'(y[0]), 0);
    check("abort_count", int'(cnt_w[0]), 0);
    rst = 1'b0;
    send(0, 8'h04, 2'b00, 1'b1);
    repeat (6) @(negedge clk);

    rand_ready = 1'b1;
    for (int r = 0; r < 60; r++) begin
      int i = $urandom_range(0, 2);
      logic [7:0] d = 8'($urandom);
      if ($urandom_range(0, 3) == 0) d = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
      if ($urandom_range(0, 3) == 0) d = d ^ (8'h01 << $urandom_range(0, 7));
      send(i, d, 2'($urandom), 1'b1);
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;

    for (t = 0; t < 200 && (sb[0].size() + sb[1].size() + sb[2].size()) != 0; t++) @(negedge clk);
    check("scoreboard_drained", sb[0].size() + sb[1].size() + sb[2].size(), 0);
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
